// File: rtl/arbitro_rr_seq.sv
// arbitro_rr_seq: round-robin arbiter moving two UART receivers into a PC mailbox and PC writes into two TX buffers.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   endereco, escrita, leitura    PC address with one-cycle write/read strobes
//   dadoPC, ocupadoPC             PC write data; PC busy blocks new grants and TX launches
//   readyRx0/1, dadoRx0/1         receiver byte valid (level) and byte
//   reseta0/1                     one-cycle receiver clear pulse on grant
//   DadoProntoMem, canalRx, dadoMem  mailbox full flag, source channel, byte
//   busyTX0/1, enableTx0/1, dadoTx0/1  transmitter busy, start pulse, data
//   txCheio, erroOverflow         TX buffer full flags; sticky overflow/timeout error
// Optional: define RX_TIMEOUT_EN to drop an unread mailbox byte after TIMEOUT cycles.
module arbitro_rr_seq #(
  parameter logic [31:0] ADDR_TX0 = 32'd50,
  parameter logic [31:0] ADDR_TX1 = 32'd60,
  parameter logic [31:0] ADDR_RX = 32'd70,
  parameter int DATA_W = 8
`ifdef RX_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       endereco,
  input  logic              escrita,
  input  logic              leitura,
  input  logic [DATA_W-1:0] dadoPC,
  input  logic              ocupadoPC,
  input  logic              readyRx0,
  input  logic              readyRx1,
  input  logic [DATA_W-1:0] dadoRx0,
  input  logic [DATA_W-1:0] dadoRx1,
  input  logic              busyTX0,
  input  logic              busyTX1,
  output logic              enableTx0,
  output logic              enableTx1,
  output logic [DATA_W-1:0] dadoTx0,
  output logic [DATA_W-1:0] dadoTx1,
  output logic              reseta0,
  output logic              reseta1,
  output logic              DadoProntoMem,
  output logic              canalRx,
  output logic [DATA_W-1:0] dadoMem,
  output logic [1:0]        txCheio,
  output logic              erroOverflow
);
  typedef enum logic [1:0] {LIVRE, CAPTURA, ESPERA} state_t;
  state_t state, state_n;
  logic ptr, grant, go, ack, to;
  logic [1:0] ready, busy, wr, launch, full, en;
  assign ready = {readyRx1, readyRx0};
  assign busy = {busyTX1, busyTX0};
  // both ready: pointer decides; otherwise the only ready channel wins
  assign grant = &ready ? ptr : readyRx1;
  assign go = state == LIVRE && !ocupadoPC && |ready;
  assign ack = state == ESPERA && leitura && endereco == ADDR_RX;
`ifdef RX_TIMEOUT_EN
  logic [9:0] cnt;
  assign to = state == ESPERA && cnt == 10'(TIMEOUT - 1);
`else
  assign to = 1'b0;
`endif
  assign wr = {escrita && endereco == ADDR_TX1, escrita && endereco == ADDR_TX0};
  assign launch = full & ~busy & {2{!ocupadoPC}};
  assign txCheio = full;
  assign enableTx0 = en[0];
  assign enableTx1 = en[1];
  // canalRx already holds the granted channel while in CAPTURA
  assign reseta0 = state == CAPTURA && !canalRx;
  assign reseta1 = state == CAPTURA && canalRx;
  always_ff @(posedge clock)
    if (reset) state <= LIVRE;
    else state <= state_n;
  always_comb begin
    state_n = go ? CAPTURA : state == CAPTURA ? ESPERA : (ack || to) ? LIVRE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
      canalRx <= 1'b0;
      dadoMem <= '0;
      DadoProntoMem <= 1'b0;
      full <= 2'b00;
      en <= 2'b00;
      dadoTx0 <= '0;
      dadoTx1 <= '0;
      erroOverflow <= 1'b0;
`ifdef RX_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      if (go) begin
        dadoMem <= grant ? dadoRx1 : dadoRx0;
        canalRx <= grant;
      end
      if (state == CAPTURA) begin
        DadoProntoMem <= 1'b1;
        ptr <= ~canalRx;
      end
      if (ack || to) DadoProntoMem <= 1'b0;
`ifdef RX_TIMEOUT_EN
      cnt <= state == ESPERA ? cnt + 10'd1 : '0;
`endif
      // a launch clears the flag on this edge, so a same-cycle write still sees it full
      full <= (full & ~launch) | (wr & ~full);
      en <= launch;
      if (wr[0] && !full[0]) dadoTx0 <= dadoPC;
      if (wr[1] && !full[1]) dadoTx1 <= dadoPC;
      erroOverflow <= erroOverflow | |(wr & full) | to;
    end
  end
endmodule

// File: tb/tb_arbitro_rr_seq.sv
// tb_arbitro_rr_seq: self-checking bench for arbitro_rr_seq using an expected-value queue.
module tb_arbitro_rr_seq;
  logic clock = 0, reset = 1;
  logic [31:0] endereco = 0;
  logic escrita = 0, leitura = 0, ocupadoPC = 0;
  logic readyRx0 = 0, readyRx1 = 0, busyTX0 = 0, busyTX1 = 0;
  logic [7:0] dadoPC = 0, dadoRx0 = 0, dadoRx1 = 0;
  logic enableTx0, enableTx1, reseta0, reseta1, DadoProntoMem, canalRx, erroOverflow;
  logic [7:0] dadoTx0, dadoTx1, dadoMem;
  logic [1:0] txCheio;
  int checks = 0, failures = 0;
  typedef struct packed {logic ch; logic [7:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  arbitro_rr_seq dut (
    .clock(clock), .reset(reset), .endereco(endereco), .escrita(escrita), .leitura(leitura),
    .dadoPC(dadoPC), .ocupadoPC(ocupadoPC), .readyRx0(readyRx0), .readyRx1(readyRx1),
    .dadoRx0(dadoRx0), .dadoRx1(dadoRx1), .busyTX0(busyTX0), .busyTX1(busyTX1),
    .enableTx0(enableTx0), .enableTx1(enableTx1), .dadoTx0(dadoTx0), .dadoTx1(dadoTx1),
    .reseta0(reseta0), .reseta1(reseta1), .DadoProntoMem(DadoProntoMem), .canalRx(canalRx),
    .dadoMem(dadoMem), .txCheio(txCheio), .erroOverflow(erroOverflow)
  );
  always #5 clock = ~clock;

  task tick;
    @(posedge clock);
    #1;
  endtask

  task do_reset;
    reset = 1; escrita = 0; leitura = 0; ocupadoPC = 0; endereco = 0;
    readyRx0 = 0; readyRx1 = 0; busyTX0 = 0; busyTX1 = 0;
    tick; tick;
    reset = 0;
    q.delete();
  endtask

  task test_reset;
    do_reset;
    checks++;
    if ({enableTx0, enableTx1, dadoTx0, dadoTx1, reseta0, reseta1, DadoProntoMem, canalRx, dadoMem, txCheio, erroOverflow} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {enableTx0, enableTx1, dadoTx0, dadoTx1, reseta0, reseta1, DadoProntoMem, canalRx, dadoMem, txCheio, erroOverflow});
    end
    tick; tick;
    checks++;
    if ({reseta1, reseta0, DadoProntoMem} !== 3'b000) begin
      failures++;
      $display("FAIL idle_no_grant got=%b exp=000", {reseta1, reseta0, DadoProntoMem});
    end
  endtask

  task test_rx_single;
    do_reset;
    readyRx0 = 1; dadoRx0 = 8'hA5;
    q.push_back('{ch: 1'b0, d: 8'hA5});
    tick;
    checks++;
    if ({reseta1, reseta0, DadoProntoMem} !== 3'b010) begin
      failures++;
      $display("FAIL single_reseta got=%b exp=010", {reseta1, reseta0, DadoProntoMem});
    end
    readyRx0 = 0;
    tick;
    e = q.pop_front();
    checks++;
    if ({reseta0, DadoProntoMem, canalRx, dadoMem} !== {1'b0, 1'b1, e}) begin
      failures++;
      $display("FAIL single_mailbox got=%h exp=%h", {reseta0, DadoProntoMem, canalRx, dadoMem}, {1'b0, 1'b1, e});
    end
    leitura = 1; endereco = 32'd71;
    tick;
    leitura = 0;
    checks++;
    if (DadoProntoMem !== 1'b1) begin
      failures++;
      $display("FAIL read_wrong_addr got=%b exp=1", DadoProntoMem);
    end
    leitura = 1; endereco = 32'd70;
    tick;
    leitura = 0;
    checks++;
    if (DadoProntoMem !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got=%b exp=0", DadoProntoMem);
    end
  endtask

  task test_rx_rr;
    int n;
    do_reset;
    readyRx0 = 1; readyRx1 = 1; dadoRx0 = 8'h11; dadoRx1 = 8'h22;
    for (int k = 0; k < 4; k++) q.push_back('{ch: k[0], d: k[0] ? 8'h22 : 8'h11});
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(reseta0 || reseta1) && n < 10) begin
        tick;
        n++;
      end
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL rr_grant_latency k=%0d got=%0d exp=1", k, n);
      end
      e = q.pop_front();
      checks++;
      if ({reseta1, reseta0} !== (e.ch ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_reseta k=%0d got=%b exp_ch=%b", k, {reseta1, reseta0}, e.ch);
      end
      tick;
      checks++;
      if ({DadoProntoMem, canalRx, dadoMem} !== {1'b1, e}) begin
        failures++;
        $display("FAIL rr_mailbox k=%0d got=%h exp=%h", k, {DadoProntoMem, canalRx, dadoMem}, {1'b1, e});
      end
      leitura = 1; endereco = 32'd70;
      tick;
      leitura = 0;
    end
    readyRx0 = 0; readyRx1 = 0;
  endtask

  task test_tx_launch;
    do_reset;
    busyTX0 = 1; escrita = 1; endereco = 32'd50; dadoPC = 8'h3C;
    q.push_back('{ch: 1'b0, d: 8'h3C});
    tick;
    escrita = 0;
    tick; tick;
    checks++;
    if ({txCheio, enableTx0, dadoTx0} !== {2'b01, 1'b0, 8'h3C}) begin
      failures++;
      $display("FAIL tx_hold got=%h exp=%h", {txCheio, enableTx0, dadoTx0}, {2'b01, 1'b0, 8'h3C});
    end
    busyTX0 = 0;
    tick;
    e = q.pop_front();
    checks++;
    if ({enableTx0, enableTx1, txCheio, dadoTx0} !== {1'b1, 1'b0, 2'b00, e.d}) begin
      failures++;
      $display("FAIL tx_launch got=%h exp=%h", {enableTx0, enableTx1, txCheio, dadoTx0}, {1'b1, 1'b0, 2'b00, e.d});
    end
    tick;
    checks++;
    if ({enableTx0, dadoTx0, erroOverflow} !== {1'b0, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL tx_single_pulse got=%h exp=%h", {enableTx0, dadoTx0, erroOverflow}, {1'b0, 8'h3C, 1'b0});
    end
  endtask

  task test_tx_overflow;
    do_reset;
    busyTX1 = 1; escrita = 1; endereco = 32'd60; dadoPC = 8'hAA;
    q.push_back('{ch: 1'b1, d: 8'hAA});
    tick;
    checks++;
    if ({erroOverflow, txCheio} !== 3'b010) begin
      failures++;
      $display("FAIL ovf_first_write got=%b exp=010", {erroOverflow, txCheio});
    end
    dadoPC = 8'hBB;
    tick;
    escrita = 0;
    checks++;
    if ({erroOverflow, txCheio, dadoTx1} !== {1'b1, 2'b10, 8'hAA}) begin
      failures++;
      $display("FAIL ovf_second_write got=%h exp=%h", {erroOverflow, txCheio, dadoTx1}, {1'b1, 2'b10, 8'hAA});
    end
    busyTX1 = 0; escrita = 1; dadoPC = 8'hCC;
    tick;
    escrita = 0;
    e = q.pop_front();
    checks++;
    if ({enableTx1, txCheio, dadoTx1} !== {1'b1, 2'b00, e.d}) begin
      failures++;
      $display("FAIL write_launch_same got=%h exp=%h", {enableTx1, txCheio, dadoTx1}, {1'b1, 2'b00, e.d});
    end
    tick;
    checks++;
    if ({enableTx1, txCheio, erroOverflow} !== 4'b0001) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=0001", {enableTx1, txCheio, erroOverflow});
    end
  endtask

  task test_ocupado;
    do_reset;
    ocupadoPC = 1;
    escrita = 1; endereco = 32'd50; dadoPC = 8'h5A;
    tick;
    endereco = 32'd60; dadoPC = 8'h6B;
    tick;
    escrita = 0;
    readyRx1 = 1; dadoRx1 = 8'h77;
    q.push_back('{ch: 1'b1, d: 8'h77});
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({reseta1, enableTx0, enableTx1, txCheio} !== 5'b00011) begin
        failures++;
        $display("FAIL ocupado_block i=%0d got=%b exp=00011", i, {reseta1, enableTx0, enableTx1, txCheio});
      end
    end
    ocupadoPC = 0;
    tick;
    readyRx1 = 0;
    checks++;
    if ({reseta1, enableTx0, enableTx1, txCheio, dadoTx0, dadoTx1} !== {5'b11100, 8'h5A, 8'h6B}) begin
      failures++;
      $display("FAIL ocupado_release got=%h exp=%h", {reseta1, enableTx0, enableTx1, txCheio, dadoTx0, dadoTx1}, {5'b11100, 8'h5A, 8'h6B});
    end
    tick;
    e = q.pop_front();
    checks++;
    if ({DadoProntoMem, canalRx, dadoMem} !== {1'b1, e}) begin
      failures++;
      $display("FAIL ocupado_mailbox got=%h exp=%h", {DadoProntoMem, canalRx, dadoMem}, {1'b1, e});
    end
  endtask

  task test_reset_mid;
    do_reset;
    readyRx0 = 1; dadoRx0 = 8'h42; busyTX0 = 1;
    escrita = 1; endereco = 32'd50; dadoPC = 8'h99;
    tick;
    readyRx0 = 0; escrita = 0;
    tick;
    checks++;
    if ({DadoProntoMem, txCheio} !== 3'b101) begin
      failures++;
      $display("FAIL mid_setup got=%b exp=101", {DadoProntoMem, txCheio});
    end
    reset = 1;
    tick;
    checks++;
    if ({DadoProntoMem, txCheio, dadoMem, enableTx0, reseta0, reseta1} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0", {DadoProntoMem, txCheio, dadoMem, enableTx0, reseta0, reseta1});
    end
    reset = 0;
    busyTX0 = 0;
    tick;
    checks++;
    if ({enableTx0, reseta0} !== 2'b00) begin
      failures++;
      $display("FAIL mid_no_pulse got=%b exp=00", {enableTx0, reseta0});
    end
  endtask

`ifdef RX_TIMEOUT_EN
  task test_timeout;
    int n;
    do_reset;
    readyRx0 = 1; dadoRx0 = 8'h0F;
    tick;
    readyRx0 = 0;
    tick;
    n = 0;
    while (DadoProntoMem && n < 1100) begin
      tick;
      n++;
    end
    checks++;
    if (n != 1023 || erroOverflow !== 1'b1) begin
      failures++;
      $display("FAIL timeout_drop cycles=%0d ovf=%b exp=1023/1", n, erroOverflow);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_rx_single;
    test_rx_rr;
    test_tx_launch;
    test_tx_overflow;
    test_ocupado;
    test_reset_mid;
`ifdef RX_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arbitro_rr_seq.md
Name: arbitro_rr_seq

Overview:
Sequential round-robin arbiter between the two UART channels and the processor (PC).
- RX side: picks one ready receiver at a time, captures its byte into a mailbox, and holds it for the PC until a read strobe acknowledges it.
- TX side: accepts PC writes to the per-channel TX addresses into one-entry buffers, then launches each transmitter when it is idle.
- Replaces fixed RX0 priority with alternating fairness and registered handshakes.

Parameters:
ADDR_TX0, 32'd50, address that targets the channel-0 TX buffer
ADDR_TX1, 32'd60, address that targets the channel-1 TX buffer
ADDR_RX, 32'd70, mailbox read address
DATA_W, 8, UART data width
TIMEOUT, 1023, mailbox hold limit in cycles (used only with RX_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
endereco  in  32  PC address
escrita  in  1  PC write strobe, one cycle
leitura  in  1  PC read strobe, one cycle
dadoPC  in  DATA_W  PC write data
ocupadoPC  in  1  PC busy; while high, no new grant and no TX launch
readyRx0, readyRx1  in  1  receiver byte valid, level, held until reseta
dadoRx0, dadoRx1  in  DATA_W  receiver bytes
busyTX0, busyTX1  in  1  transmitter busy
enableTx0, enableTx1  out  1  one-cycle TX start pulse
dadoTx0, dadoTx1  out  DATA_W  TX data, valid while the buffer is full
reseta0, reseta1  out  1  one-cycle receiver clear pulse
DadoProntoMem  out  1  mailbox holds unread byte
canalRx  out  1  source channel of the mailbox byte
dadoMem  out  DATA_W  mailbox byte
txCheio  out  2  TX buffer full flags, bit n = channel n
erroOverflow  out  1  sticky: write to a full TX buffer, or timeout drop

Behaviour:
Reset:
- All outputs are 0.
- RX FSM goes to LIVRE; round-robin pointer ptr = 0; TX buffers are empty.
- A reset mid-transfer discards the mailbox and the buffers with no pulses emitted.

RX FSM (LIVRE, CAPTURA, ESPERA):
- LIVRE: if !ocupadoPC and any readyRx is set, grant a channel.
  - Both ready: grant channel ptr.
  - One ready: grant that channel.
  - Next cycle: dadoMem <= dadoRx[grant], canalRx <= grant, reseta[grant] = 1 for exactly one cycle; go to CAPTURA.
- CAPTURA (1 cycle): DadoProntoMem <= 1; ptr <= ~grant; go to ESPERA.
- ESPERA:
  - leitura && endereco == ADDR_RX: DadoProntoMem <= 0 next cycle; go to LIVRE.
  - A read strobe at any other address is ignored.
- Latencies:
  - readyRx rising to reseta pulse: 1 cycle.
  - readyRx rising to DadoProntoMem: 2 cycles.
  - Minimum spacing between consecutive grants: 3 cycles.
- ocupadoPC high in ESPERA does not block the acknowledge.

TX path, per channel n:
- Write accept: escrita && endereco == ADDR_TXn && !txCheio[n]: dadoTxn <= dadoPC, txCheio[n] <= 1.
- Write to a full buffer: ignored, erroOverflow <= 1.
- Launch: if txCheio[n] && !busyTXn && !ocupadoPC, enableTxn = 1 for exactly one cycle; txCheio[n] clears on the same edge; dadoTxn holds its value.
- Write and launch on the same channel in the same cycle:
  - Launch takes the old byte.
  - Write is rejected and erroOverflow is set, because the buffer is full at evaluation.
- The two channels are independent; both may launch in the same cycle.
- Addresses other than ADDR_TX0, ADDR_TX1 and ADDR_RX are ignored.
- erroOverflow clears only on reset.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined:
  - A 10-bit counter runs in ESPERA and resets on entry.
  - Reaching TIMEOUT drops the mailbox (DadoProntoMem <= 0), sets erroOverflow, and returns to LIVRE.
  - ptr still alternates.
- Not defined: ESPERA waits indefinitely and the counter is absent.

Test Plan:
- readyRx0=1, dadoRx0=8'hA5 from idle -> reseta0 pulse at cycle 1; DadoProntoMem=1, canalRx=0, dadoMem=A5 at cycle 2; leitura @70 -> DadoProntoMem=0 next cycle.
- readyRx0 and readyRx1 both held, data 11/22, read each promptly -> grant order 0,1,0,1; reseta pulses alternate.
- Write dadoPC=8'h3C @50 while busyTX0=1 -> txCheio=01, no enableTx0; busyTX0 drops -> enableTx0 single pulse with dadoTx0=3C, txCheio=00.
- Two writes @60 with busyTX1=1 -> second write ignored, erroOverflow=1, dadoTx1 keeps the first byte.
- ocupadoPC=1 with readyRx1=1 and a full TX0 buffer -> no reseta1, no enableTx0; release -> both proceed within 1 cycle.
- Reset asserted in ESPERA -> DadoProntoMem=0, txCheio=00 next cycle. With RX_TIMEOUT_EN, no read for 1023 cycles -> drop plus erroOverflow=1.
